// File: rtl/mem_resp.sv
// ioMem responder: fully associative line buffer in front of a backing word array, fixed miss latency.
// Optional protocol checker and hit/miss counters are built when MEM_RESP_CHECK_EN is defined.
module mem_resp #(
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          LATENCY   = 3,
  parameter int          BUF_N     = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ioMem_ren,
  input  logic [31:0] ioMem_addr,
  input  logic        ioMem_wen,
  input  logic [7:0]  ioMem_wMask,
  input  logic [63:0] ioMem_wData,
  output logic [63:0] ioMem_rData,
  output logic        ioMem_hit,
  output logic        ioMem_rvalid
`ifdef MEM_RESP_CHECK_EN
  ,
  output logic        ioMem_err,
  output logic [31:0] hitCnt,
  output logic [31:0] missCnt
`endif
);

  localparam int TAG_W = 29;
  localparam int PTR_W = (BUF_N > 1) ? $clog2(BUF_N) : 1;
  localparam int CNT_W = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [TAG_W-1:0]   req_tag;
  logic [63:0]        mem [0:(1<<ADDR_W)-1];
  logic [TAG_W-1:0]   buf_tag  [BUF_N];
  logic [63:0]        buf_data [BUF_N];
  logic [BUF_N-1:0]   buf_vld;
  logic [PTR_W-1:0]   fill_ptr;

  logic [TAG_W-1:0]   cur_tag;
  logic [TAG_W-1:0]   resp_tag;
  logic [ADDR_W-1:0]  wr_idx;
  logic [ADDR_W-1:0]  resp_idx;
  logic               is_idle;
  logic               wr_en;
  logic               hit_any;
  logic [PTR_W-1:0]   hit_sel;
  logic               miss_start;
  logic               resp_go;
  logic               resp_in;
  logic [63:0]        resp_word;
  logic [63:0]        resp_data;
  logic               unused_addr_lsb;

  function automatic logic in_range(input logic [TAG_W-1-ADDR_W:0] hi);
    return hi == BASE_ADDR[31:3+ADDR_W];
  endfunction

  function automatic logic [63:0] byte_merge(input logic [63:0] old_w,
                                             input logic [63:0] new_w,
                                             input logic [7:0]  mask);
    logic [63:0] res;
    res = old_w;
    for (int b = 0; b < 8; b++)
      if (mask[b]) res[8*b +: 8] = new_w[8*b +: 8];
    return res;
  endfunction

  assign unused_addr_lsb = ^ioMem_addr[2:0];

  assign cur_tag  = ioMem_addr[31:3];
  assign is_idle  = (state == IDLE);
  assign wr_idx   = cur_tag[ADDR_W-1:0];
  assign wr_en    = is_idle && ioMem_wen && in_range(cur_tag[TAG_W-1:ADDR_W]);

  always_comb begin
    hit_any = 1'b0;
    hit_sel = '0;
    for (int i = 0; i < BUF_N; i++) begin
      if (buf_vld[i] && (buf_tag[i] == cur_tag)) begin
        hit_any = 1'b1;
        hit_sel = PTR_W'(i);
      end
    end
  end

  // A simultaneous write forces the read down the miss path so it sees post-write data.
  assign ioMem_hit  = is_idle && ioMem_ren && !ioMem_wen && hit_any;
  assign miss_start = is_idle && ioMem_ren && !ioMem_hit;
  assign resp_go    = ((LATENCY == 1) && miss_start) ||
                      ((state == BUSY) && (cnt == CNT_W'(1)));

  // Response data is captured on the edge into RESP; forwarding covers a write landing on that edge.
  assign resp_tag  = is_idle ? cur_tag : req_tag;
  assign resp_idx  = resp_tag[ADDR_W-1:0];
  assign resp_in   = in_range(resp_tag[TAG_W-1:ADDR_W]);
  assign resp_word = (wr_en && (wr_idx == resp_idx)) ?
                     byte_merge(mem[resp_idx], ioMem_wData, ioMem_wMask) : mem[resp_idx];
  assign resp_data = resp_in ? resp_word : 64'h0;

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_idx] <= byte_merge(mem[wr_idx], ioMem_wData, ioMem_wMask);
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < BUF_N; i++) begin
      if (wr_en && buf_vld[i] && (buf_tag[i] == cur_tag))
        buf_data[i] <= byte_merge(buf_data[i], ioMem_wData, ioMem_wMask);
    end
    if (resp_go && resp_in) begin
      buf_tag[fill_ptr]  <= resp_tag;
      buf_data[fill_ptr] <= resp_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      req_tag      <= '0;
      ioMem_rData  <= 64'h0;
      ioMem_rvalid <= 1'b0;
      buf_vld      <= '0;
      fill_ptr     <= '0;
    end else begin
      ioMem_rvalid <= resp_go;
      if (resp_go)        ioMem_rData <= resp_data;
      else if (ioMem_hit) ioMem_rData <= buf_data[hit_sel];

      if (resp_go && resp_in) begin
        buf_vld[fill_ptr] <= 1'b1;
        fill_ptr <= (fill_ptr == PTR_W'(BUF_N-1)) ? '0 : fill_ptr + 1'b1;
      end

      case (state)
        IDLE: begin
          if (miss_start) begin
            req_tag <= cur_tag;
            cnt     <= CNT_W'(LATENCY-1);
            state   <= (LATENCY == 1) ? RESP : BUSY;
          end
        end
        BUSY: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_RESP_CHECK_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ioMem_err <= 1'b0;
      hitCnt    <= '0;
      missCnt   <= '0;
    end else begin
      if ((!is_idle && (ioMem_ren || ioMem_wen)) ||
          (is_idle && (ioMem_ren || ioMem_wen) && !in_range(cur_tag[TAG_W-1:ADDR_W])) ||
          (is_idle && ioMem_wen && (ioMem_wMask == 8'h00)))
        ioMem_err <= 1'b1;
      if (ioMem_hit && (hitCnt != 32'hFFFF_FFFF))   hitCnt  <= hitCnt + 1'b1;
      if (miss_start && (missCnt != 32'hFFFF_FFFF)) missCnt <= missCnt + 1'b1;
    end
  end
`endif

endmodule
